// File: rtl/inst_mem_loader.sv
// ----------------------------------------------------------------------------
// inst_mem_loader
//
// Writable instruction memory with a serial boot loader and a registered
// fetch port. After reset the memory is unreachable (length 0) until a
// program is streamed in through the loader port. Once loaded, the fetch port
// answers the program counter with one cycle of latency. Addresses at or past
// the loaded length return HALT_WORD so that a short program stops cleanly.
//
// Parameters:
//   A          address width, memory depth = 2**A words
//   W          instruction word width
//   HALT_WORD  word returned for addresses outside the loaded program
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        asynchronous active-high reset
//   LoadStart    1-cycle pulse, begin a program load (ignored while loading)
//   LoadLen      number of words to load, sampled with LoadStart
//   LoadValid    LoadData carries a word this cycle
//   LoadData     instruction word to write
//   LoadReady    loader accepts a word this cycle
//   LoadDone     1-cycle pulse after the last word is written
//   FetchReq     fetch request for InstAddress
//   InstAddress  fetch address
//   InstOut      fetched instruction (registered, holds when not fetching)
//   InstValid    InstOut was produced by a fetch on the previous edge
//   Busy         high whenever the memory is not in RUN
//   ParityErr    stored parity mismatched on the last fetch
//
// Optional feature (macro INST_MEM_PARITY_EN):
//   Each stored word carries an extra even-parity bit computed at write time.
//   Fetches recompute parity and flag a mismatch on ParityErr together with
//   InstValid. Without the macro the memory is W bits wide and ParityErr is 0.
// ----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int             A         = 10,
    parameter int             W         = 9,
    parameter logic [W-1:0]   HALT_WORD = {W{1'b1}}
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LoadStart,
    input  logic [A:0]   LoadLen,
    input  logic         LoadValid,
    input  logic [W-1:0] LoadData,
    output logic         LoadReady,
    output logic         LoadDone,
    input  logic         FetchReq,
    input  logic [A-1:0] InstAddress,
    output logic [W-1:0] InstOut,
    output logic         InstValid,
    output logic         Busy,
    output logic         ParityErr
);

`ifdef INST_MEM_PARITY_EN
    localparam int MW = W + 1;
`else
    localparam int MW = W;
`endif

    localparam int         DEPTH   = 1 << A;
    localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};
    localparam logic [A:0] LEN_ONE = {{A{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [A:0]     wr_ptr_q, wr_ptr_d;
    logic [A:0]     len_q, len_d;
    logic           done_q, done_d;
    logic [W-1:0]   inst_out_q, inst_out_d;
    logic           inst_valid_q, inst_valid_d;

    logic [MW-1:0]  mem [DEPTH];
    logic           wr_en;
    logic [MW-1:0]  wr_word;
    logic [MW-1:0]  rd_word;
    logic [A:0]     load_len_clamped;
    logic           in_range;

    // A requested length larger than the memory is clamped to full depth so
    // the write pointer can never wrap back over already-loaded words.
    always_comb begin
        load_len_clamped = (LoadLen > MAX_LEN) ? MAX_LEN : LoadLen;
    end

`ifdef INST_MEM_PARITY_EN
    always_comb begin
        wr_word = {^LoadData, LoadData};
    end
`else
    always_comb begin
        wr_word = LoadData;
    end
`endif

    // Loader FSM next-state logic. IDLE and RUN both accept a new load; a
    // zero-length load skips LOAD entirely but still pulses LoadDone.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (LoadStart) begin
                    len_d    = load_len_clamped;
                    wr_ptr_d = '0;
                    if (load_len_clamped == '0) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (LoadValid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + LEN_ONE;
                    if (wr_ptr_q == len_q - LEN_ONE) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
            done_q   <= done_d;
        end
    end

    // Memory contents survive Reset; with len cleared they are simply out of
    // range until a new load completes.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[A-1:0]] <= wr_word;
        end
    end

    // Fetch path. The read uses the length in force before this edge, so a
    // fetch issued together with LoadStart is served from the old program,
    // and a same-address write on the same edge returns the old data.
    always_comb begin
        rd_word      = mem[InstAddress];
        in_range     = {1'b0, InstAddress} < len_q;
        inst_out_d   = inst_out_q;
        inst_valid_d = 1'b0;
        if (state_q == RUN && FetchReq) begin
            inst_valid_d = 1'b1;
            inst_out_d   = in_range ? rd_word[W-1:0] : HALT_WORD;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            inst_out_q   <= HALT_WORD;
            inst_valid_q <= 1'b0;
        end else begin
            inst_out_q   <= inst_out_d;
            inst_valid_q <= inst_valid_d;
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic parity_err_q, parity_err_d;

    // XOR over data plus stored parity is zero for an intact word. HALT
    // returns never flag an error.
    always_comb begin
        parity_err_d = 1'b0;
        if (state_q == RUN && FetchReq && in_range) begin
            parity_err_d = ^rd_word;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign ParityErr = parity_err_q;
`else
    assign ParityErr = 1'b0;
`endif

    assign LoadReady = (state_q == LOAD);
    assign LoadDone  = done_q;
    assign Busy      = (state_q != RUN);
    assign InstOut   = inst_out_q;
    assign InstValid = inst_valid_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Directed testbench for inst_mem_loader (A=10, W=9, HALT_WORD=9'h1FF).
// Each scenario task drives its stimulus and checks results inline against
// hand-computed values. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, i.e. away from the active edge.
// Define INST_MEM_PARITY_EN to also exercise the parity scenario.
// ----------------------------------------------------------------------------
module tb_inst_mem_loader;

    logic        Clk;
    logic        Reset;
    logic        LoadStart;
    logic [10:0] LoadLen;
    logic        LoadValid;
    logic [8:0]  LoadData;
    logic        LoadReady;
    logic        LoadDone;
    logic        FetchReq;
    logic [9:0]  InstAddress;
    logic [8:0]  InstOut;
    logic        InstValid;
    logic        Busy;
    logic        ParityErr;

    int checks   = 0;
    int failures = 0;

    logic [8:0] prog [4] = '{9'h0A8, 9'h0D2, 9'h16D, 9'h122};

    inst_mem_loader dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .LoadStart   (LoadStart),
        .LoadLen     (LoadLen),
        .LoadValid   (LoadValid),
        .LoadData    (LoadData),
        .LoadReady   (LoadReady),
        .LoadDone    (LoadDone),
        .FetchReq    (FetchReq),
        .InstAddress (InstAddress),
        .InstOut     (InstOut),
        .InstValid   (InstValid),
        .Busy        (Busy),
        .ParityErr   (ParityErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Absolute time limit so the bench always ends on its own.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Streams the first n words of prog with LoadValid held high.
    task automatic load_program(input int n, input logic [10:0] len);
        LoadStart = 1'b1;
        LoadLen   = len;
        tick();
        LoadStart = 1'b0;
        for (int i = 0; i < n; i++) begin
            LoadValid = 1'b1;
            LoadData  = prog[i];
            tick();
        end
        LoadValid = 1'b0;
    endtask

    task automatic fetch(input logic [9:0] addr);
        FetchReq    = 1'b1;
        InstAddress = addr;
        tick();
        FetchReq    = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; LoadStart = 1'b0; LoadLen = '0; LoadValid = 1'b0;
        LoadData = '0; FetchReq = 1'b1; InstAddress = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        checks++; if (Busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=1", Busy); end
        checks++; if (LoadReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", LoadReady); end
        checks++; if (LoadDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", LoadDone); end
        checks++; if (InstOut !== 9'h1FF) begin failures++; $display("[TB] FAIL reset_inst_out got=%h exp=1ff", InstOut); end
        checks++; if (ParityErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_parity got=%b exp=0", ParityErr); end
        tick(); tick();
        checks++; if (InstValid !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_fetch got=%b exp=0", InstValid); end
        checks++; if (Busy !== 1'b1) begin failures++; $display("[TB] FAIL idle_busy got=%b exp=1", Busy); end
        // Zero-length load goes straight to RUN.
        FetchReq = 1'b0; LoadStart = 1'b1; LoadLen = '0;
        tick();
        LoadStart = 1'b0;
        checks++; if (LoadDone !== 1'b1) begin failures++; $display("[TB] FAIL len0_done got=%b exp=1", LoadDone); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL len0_busy got=%b exp=0", Busy); end
        fetch(10'd0);
        checks++; if (LoadDone !== 1'b0) begin failures++; $display("[TB] FAIL len0_done_pulse got=%b exp=0", LoadDone); end
        checks++; if (InstValid !== 1'b1) begin failures++; $display("[TB] FAIL len0_valid got=%b exp=1", InstValid); end
        checks++; if (InstOut !== 9'h1FF) begin failures++; $display("[TB] FAIL len0_inst got=%h exp=1ff", InstOut); end
    endtask

    task automatic test_load_four();
        int ready_cnt = 0;
        int done_cnt  = 0;
        logic [9:0] order [5] = '{10'd4, 10'd0, 10'd1, 10'd2, 10'd3};
        logic [8:0] expv  [5] = '{9'h1FF, 9'h0A8, 9'h0D2, 9'h16D, 9'h122};
        LoadStart = 1'b1; LoadLen = 11'd4;
        tick();
        LoadStart = 1'b0;
        checks++; if (Busy !== 1'b1) begin failures++; $display("[TB] FAIL load4_busy got=%b exp=1", Busy); end
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                LoadValid = 1'b1; LoadData = prog[c];
            end else begin
                LoadValid = 1'b0;
            end
            if (LoadReady) ready_cnt++;
            tick();
            if (LoadDone) done_cnt++;
        end
        checks++; if (ready_cnt != 4) begin failures++; $display("[TB] FAIL load4_ready_cycles got=%0d exp=4", ready_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL load4_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL load4_busy_fall got=%b exp=0", Busy); end
        // Back-to-back fetches, one per cycle.
        FetchReq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            InstAddress = order[i];
            tick();
            checks++; if (InstValid !== 1'b1 || InstOut !== expv[i] || ParityErr !== 1'b0) begin
                failures++;
                $display("[TB] FAIL load4_fetch_%0d got=%h/%b/%b exp=%h/1/0", order[i], InstOut, InstValid, ParityErr, expv[i]);
            end
        end
        FetchReq = 1'b0;
        tick();
        checks++; if (InstValid !== 1'b0 || InstOut !== 9'h122) begin
            failures++; $display("[TB] FAIL load4_hold got=%h/%b exp=122/0", InstOut, InstValid);
        end
    endtask

    task automatic test_valid_gaps();
        logic [8:0] data [5] = '{9'h101, 9'h0EE, 9'h102, 9'h0DD, 9'h103};
        logic       vld  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int early_done = 0;
        LoadStart = 1'b1; LoadLen = 11'd3;
        tick();
        LoadStart = 1'b0;
        for (int c = 0; c < 5; c++) begin
            LoadValid = vld[c]; LoadData = data[c];
            tick();
            if (c < 4 && LoadDone) early_done++;
        end
        LoadValid = 1'b0;
        checks++; if (early_done != 0) begin failures++; $display("[TB] FAIL gaps_early_done got=%0d exp=0", early_done); end
        checks++; if (LoadDone !== 1'b1) begin failures++; $display("[TB] FAIL gaps_done got=%b exp=1", LoadDone); end
        fetch(10'd2);
        checks++; if (InstOut !== 9'h103) begin failures++; $display("[TB] FAIL gaps_addr2 got=%h exp=103", InstOut); end
        fetch(10'd1);
        checks++; if (InstOut !== 9'h102) begin failures++; $display("[TB] FAIL gaps_addr1 got=%h exp=102", InstOut); end
        fetch(10'd3);
        checks++; if (InstOut !== 9'h1FF) begin failures++; $display("[TB] FAIL gaps_addr3 got=%h exp=1ff", InstOut); end
    endtask

    task automatic test_reset_midload();
        LoadStart = 1'b1; LoadLen = 11'd5;
        tick();
        LoadStart = 1'b0;
        LoadValid = 1'b1; LoadData = 9'h011; tick();
        LoadData = 9'h022; tick();
        LoadValid = 1'b0;
        FetchReq = 1'b1; InstAddress = '0;
        Reset = 1'b1;
        #1;
        checks++; if (LoadReady !== 1'b0 || Busy !== 1'b1) begin
            failures++; $display("[TB] FAIL midreset_state got ready=%b busy=%b exp ready=0 busy=1", LoadReady, Busy);
        end
        checks++; if (InstValid !== 1'b0 || InstOut !== 9'h1FF) begin
            failures++; $display("[TB] FAIL midreset_outputs got=%h/%b exp=1ff/0", InstOut, InstValid);
        end
        @(posedge Clk); #1 Reset = 1'b0;
        tick();
        checks++; if (InstValid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_idle_fetch got=%b exp=0", InstValid); end
        LoadStart = 1'b1; LoadLen = '0;
        tick();
        LoadStart = 1'b0;
        tick();
        FetchReq = 1'b0;
        checks++; if (InstValid !== 1'b1 || InstOut !== 9'h1FF) begin
            failures++; $display("[TB] FAIL midreset_reload got=%h/%b exp=1ff/1", InstOut, InstValid);
        end
    endtask

    task automatic test_reload_in_run();
        load_program(4, 11'd4);
        checks++; if (LoadDone !== 1'b1) begin failures++; $display("[TB] FAIL reload_first_done got=%b exp=1", LoadDone); end
        // Fetch issued together with LoadStart is served from the old program.
        LoadStart = 1'b1; LoadLen = 11'd2; FetchReq = 1'b1; InstAddress = 10'd0;
        tick();
        LoadStart = 1'b0;
        checks++; if (InstValid !== 1'b1 || InstOut !== 9'h0A8 || Busy !== 1'b1) begin
            failures++; $display("[TB] FAIL reload_turnaround got=%h/%b busy=%b exp=0a8/1 busy=1", InstOut, InstValid, Busy);
        end
        LoadValid = 1'b1; LoadData = 9'h001;
        tick();
        checks++; if (InstValid !== 1'b0) begin failures++; $display("[TB] FAIL reload_fetch_in_load got=%b exp=0", InstValid); end
        LoadData = 9'h002;
        tick();
        LoadValid = 1'b0; FetchReq = 1'b0;
        checks++; if (InstValid !== 1'b0 || LoadDone !== 1'b1 || InstOut !== 9'h0A8) begin
            failures++; $display("[TB] FAIL reload_done got=%h/%b done=%b exp=0a8/0 done=1", InstOut, InstValid, LoadDone);
        end
        fetch(10'd1);
        checks++; if (InstOut !== 9'h002) begin failures++; $display("[TB] FAIL reload_addr1 got=%h exp=002", InstOut); end
        fetch(10'd3);
        checks++; if (InstOut !== 9'h1FF) begin failures++; $display("[TB] FAIL reload_addr3 got=%h exp=1ff", InstOut); end
        fetch(10'd0);
        checks++; if (InstOut !== 9'h001) begin failures++; $display("[TB] FAIL reload_addr0 got=%h exp=001", InstOut); end
    endtask

    task automatic test_clamp();
        int early_done = 0;
        LoadStart = 1'b1; LoadLen = 11'h7FF;
        tick();
        LoadStart = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            LoadValid = 1'b1;
            LoadData  = 9'(i) ^ 9'h155;
            tick();
            if (i < 1023 && LoadDone) early_done++;
        end
        LoadValid = 1'b0;
        checks++; if (early_done != 0 || LoadDone !== 1'b1) begin
            failures++; $display("[TB] FAIL clamp_done got early=%0d done=%b exp early=0 done=1", early_done, LoadDone);
        end
        fetch(10'd1023);
        checks++; if (InstOut !== 9'h0AA) begin failures++; $display("[TB] FAIL clamp_addr1023 got=%h exp=0aa", InstOut); end
        fetch(10'd700);
        checks++; if (InstOut !== 9'h1E9) begin failures++; $display("[TB] FAIL clamp_addr700 got=%h exp=1e9", InstOut); end
        fetch(10'd0);
        checks++; if (InstOut !== 9'h155) begin failures++; $display("[TB] FAIL clamp_addr0 got=%h exp=155", InstOut); end
    endtask

`ifdef INST_MEM_PARITY_EN
    task automatic test_parity();
        load_program(2, 11'd2);
        tick();
        dut.mem[1] = dut.mem[1] ^ 10'h004;
        fetch(10'd1);
        checks++; if (ParityErr !== 1'b1 || InstValid !== 1'b1 || InstOut !== 9'h0D6) begin
            failures++; $display("[TB] FAIL parity_bad got=%h/%b err=%b exp=0d6/1 err=1", InstOut, InstValid, ParityErr);
        end
        fetch(10'd0);
        checks++; if (ParityErr !== 1'b0 || InstOut !== 9'h0A8) begin
            failures++; $display("[TB] FAIL parity_good got=%h err=%b exp=0a8 err=0", InstOut, ParityErr);
        end
        fetch(10'd5);
        checks++; if (ParityErr !== 1'b0 || InstOut !== 9'h1FF) begin
            failures++; $display("[TB] FAIL parity_halt got=%h err=%b exp=1ff err=0", InstOut, ParityErr);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting inst_mem_loader bench");
        test_reset();
        test_load_four();
        test_valid_gaps();
        test_reset_midload();
        test_reload_in_run();
        test_clamp();
`ifdef INST_MEM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Parametrised, writable instruction memory that replaces the fixed, hard-coded instruction ROM.
- A serial boot-loader port fills the memory after reset.
- A registered fetch port then serves the program counter with 1-cycle latency.
- Addresses at or beyond the loaded program length return the HALT word, so a short program halts cleanly.

Parameters:
- A, 10, address width; memory depth = 2**A words
- W, 9, instruction word width
- HALT_WORD, {W{1'b1}}, word returned for unloaded/out-of-range addresses

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- LoadStart  in  1  1-cycle pulse: begin a program load
- LoadLen  in  A+1  number of words to load; sampled on LoadStart
- LoadValid  in  1  LoadData is valid this cycle
- LoadData  in  W  instruction word to write
- LoadReady  out  1  loader accepts a word this cycle
- LoadDone  out  1  1-cycle pulse: load complete
- FetchReq  in  1  fetch request for InstAddress
- InstAddress  in  A  fetch address
- InstOut  out  W  fetched instruction (registered)
- InstValid  out  1  InstOut valid this cycle
- Busy  out  1  high while state != RUN
- ParityErr  out  1  parity error on the last fetch (see Optional Feature)

Behaviour:
- Memory: 2**A x W array, synchronous write. Contents are not cleared by Reset.
- Registers:
  - state ∈ {IDLE, LOAD, RUN}
  - wr_ptr [A:0]
  - len [A:0], the loaded program length
- Reset (async): state=IDLE, wr_ptr=0, len=0. Outputs: LoadReady=0, LoadDone=0, InstOut=HALT_WORD, InstValid=0, Busy=1, ParityErr=0.
- IDLE:
  - LoadStart=1 -> LOAD; len<=LoadLen; wr_ptr<=0.
  - If LoadLen=0: go directly to RUN and pulse LoadDone next cycle.
- LOAD:
  - LoadReady=1.
  - On LoadValid&LoadReady: mem[wr_ptr]<=LoadData; wr_ptr<=wr_ptr+1.
  - When the write hits wr_ptr==len-1: -> RUN, LoadDone=1 for exactly the following cycle.
  - LoadValid with LoadReady=0 is ignored (word dropped, no write).
  - LoadStart in LOAD is ignored.
- RUN:
  - LoadReady=0, Busy=0.
  - LoadStart=1 -> LOAD with new len and wr_ptr=0; Busy rises the next cycle.
  - A fetch issued in the same cycle as LoadStart is still served.
- Fetch:
  - In RUN, FetchReq=1 at edge N -> InstValid=1 and InstOut valid after edge N+1 (1-cycle latency).
  - InstOut = mem[InstAddress] if InstAddress < len, else HALT_WORD.
  - FetchReq=0, or state != RUN: InstValid=0 next cycle and InstOut holds its last value.
- LoadLen > 2**A: clamp len to 2**A; wr_ptr never wraps.
- Write/read collision (fetch during the RUN->LOAD turnaround, same address): read returns old data.
- Reset mid-load:
  - Immediate return to IDLE, len=0.
  - All fetches return HALT_WORD until a new load completes.
  - Partially written memory is retained but unreachable.

Optional Feature:
- Macro INST_MEM_PARITY_EN.
- When defined:
  - Memory stores W+1 bits; the extra bit is the even parity of LoadData, computed at write.
  - On fetch, parity is recomputed. ParityErr=1 alongside InstValid if it mismatches, else 0.
  - HALT_WORD returns for out-of-range addresses never flag an error.
- When undefined: memory is W bits wide and ParityErr is tied 0.

Test Plan:
- Reset, no load; FetchReq=1, InstAddress=0 -> after reset Busy=1, InstValid=0 (no fetch served in IDLE). After LoadStart with LoadLen=0 -> LoadDone pulse, then a fetch of addr 0 gives InstOut=9'h1FF, InstValid=1.
- LoadLen=4; stream 9'h0A8, 9'h0D2, 9'h16D, 9'h122 with LoadValid=1 each cycle:
  - LoadReady high 4 cycles; LoadDone pulses once; Busy falls.
  - Fetches of addr 0..3 -> the same 4 words, each 1 cycle after request.
  - Fetch of addr 4 -> 9'h1FF.
- LoadLen=3 with LoadValid toggling 1,0,1,0,1: exactly 3 writes. LoadDone follows the 3rd accepted word; fetch of addr 2 = the 3rd word.
- Assert Reset after 2 of 5 words loaded -> state IDLE, LoadReady=0, InstValid=0. Fetch of addr 0 after reloading with LoadLen=0 -> 9'h1FF.
- In RUN after a 4-word load, pulse LoadStart with LoadLen=2 and load 9'h001, 9'h002:
  - Fetches during LOAD -> InstValid=0.
  - After LoadDone: addr 1 -> 9'h002; addr 3 -> 9'h1FF (beyond new len).
- With INST_MEM_PARITY_EN: load a 2-word program, force-flip a stored data bit of addr 1 via the bench. Fetch addr 1 -> ParityErr=1; fetch addr 0 -> ParityErr=0; fetch addr 5 -> HALT_WORD with ParityErr=0.
